// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the three-master AHB round-robin arbiter.
package ahb_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] M_NONE      = 2'b00;
  localparam logic [1:0] M1          = 2'b01;
  localparam logic [1:0] M2          = 2'b10;
  localparam logic [1:0] M3          = 2'b11;
  localparam logic [1:0] SEL_DEFAULT = 2'b00;

  // Master ID to grant vector; bit 0 is master 1.
  function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
    logic [2:0] v;
    v = 3'b000;
    case (id)
      M1:      v = 3'b001;
      M2:      v = 3'b010;
      M3:      v = 3'b011 ^ 3'b111;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin winner search: starts after `last`, wraps 3 -> 1.
module ahb_rr_pick
  import ahb_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any_req
);

  always_comb begin
    winner  = M_NONE;
    any_req = |req;
    case (last)
      M1: begin
        if (req[1])      winner = M2;
        else if (req[2]) winner = M3;
        else if (req[0]) winner = M1;
      end
      M2: begin
        if (req[2])      winner = M3;
        else if (req[0]) winner = M1;
        else if (req[1]) winner = M2;
      end
      // last = M3, and the never-expected M_NONE, both start at master 1
      default: begin
        if (req[0])      winner = M1;
        else if (req[1]) winner = M2;
        else if (req[2]) winner = M3;
      end
    endcase
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Three-master AHB round-robin arbiter with per-tenure beat quantum and one idle cycle per handover.
// Optional `ARB_LOCK_EN adds hlock_1..3, which suppress the quantum release for a locked owner.
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic       hreq_1,
  input  logic       hreq_2,
  input  logic       hreq_3,
  input  logic [1:0] sel_1,
  input  logic [1:0] sel_2,
  input  logic [1:0] sel_3,
`ifdef ARB_LOCK_EN
  input  logic       hlock_1,
  input  logic       hlock_2,
  input  logic       hlock_3,
`endif
  input  logic       hready_out,
  input  logic       hresp,
  output logic       hgrant_1,
  output logic       hgrant_2,
  output logic       hgrant_3,
  output logic [1:0] sel,
  output logic [1:0] hmaster,
  output logic       arb_err
);

  state_t           state;
  logic [1:0]       owner;
  logic [1:0]       last;
  logic [CNT_W-1:0] beat_cnt;
  logic [2:0]       grant;

  logic [2:0] req;
  logic [2:0] lock;
  logic [1:0] winner;
  logic       any_req;
  logic [1:0] winner_sel;
  logic [1:0] owner_sel;
  logic       owner_req;
  logic       owner_lock;
  logic       done;
  logic       err;
  logic       other;
  logic       last_beat;
  logic       release_now;

  assign req = {hreq_3, hreq_2, hreq_1};

`ifdef ARB_LOCK_EN
  assign lock = {hlock_3, hlock_2, hlock_1};
`else
  assign lock = 3'b000;
`endif

  ahb_rr_pick u_pick (
    .req     (req),
    .last    (last),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    winner_sel = SEL_DEFAULT;
    case (winner)
      M1:      winner_sel = sel_1;
      M2:      winner_sel = sel_2;
      M3:      winner_sel = sel_3;
      default: winner_sel = SEL_DEFAULT;
    endcase
  end

  always_comb begin
    owner_sel  = SEL_DEFAULT;
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    case (owner)
      M1: begin owner_sel = sel_1; owner_req = req[0]; owner_lock = lock[0]; end
      M2: begin owner_sel = sel_2; owner_req = req[1]; owner_lock = lock[1]; end
      M3: begin owner_sel = sel_3; owner_req = req[2]; owner_lock = lock[2]; end
      default: begin owner_sel = SEL_DEFAULT; owner_req = 1'b0; owner_lock = 1'b0; end
    endcase
  end

  assign done      = hready_out & ~hresp;
  assign err       = hready_out & hresp;
  assign other     = |(req & ~id_to_onehot(owner));
  assign last_beat = (beat_cnt == CNT_W'(MAX_BEATS - 1));

  // Every release term carries hready_out, so wait states always hold the grant.
  assign release_now = err
                     | (hready_out & ~owner_req)
                     | (done & last_beat & other & ~owner_lock);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= IDLE;
      owner    <= M_NONE;
      last     <= M3;
      beat_cnt <= '0;
      grant    <= 3'b000;
      sel      <= SEL_DEFAULT;
      hmaster  <= M_NONE;
      arb_err  <= 1'b0;
    end else if (state == IDLE) begin
      arb_err <= 1'b0;
      if (any_req) begin
        state    <= GRANT;
        owner    <= winner;
        last     <= winner;
        beat_cnt <= '0;
        grant    <= id_to_onehot(winner);
        sel      <= winner_sel;
        hmaster  <= winner;
      end else begin
        grant   <= 3'b000;
        sel     <= SEL_DEFAULT;
        hmaster <= M_NONE;
      end
    end else begin
      arb_err <= err;
      if (release_now) begin
        state <= IDLE;
        owner <= M_NONE;
        grant <= 3'b000;
        sel   <= SEL_DEFAULT;
        // On an error release hmaster keeps naming the faulting master
        // for the arb_err cycle; the idle cycle then overwrites it.
        hmaster <= err ? owner : M_NONE;
      end else begin
        if (done && !last_beat) beat_cnt <= beat_cnt + CNT_W'(1);
        sel <= owner_sel;
      end
    end
  end

  assign hgrant_1 = grant[0];
  assign hgrant_2 = grant[1];
  assign hgrant_3 = grant[2];

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_ahb_rr_arbiter;
  import ahb_arb_pkg::*;

  localparam int MAX_BEATS = 4;

  logic       hclk = 1'b0;
  logic       hreset = 1'b1;
  logic       hreq_1 = 1'b0, hreq_2 = 1'b0, hreq_3 = 1'b0;
  logic [1:0] sel_1 = 2'b00, sel_2 = 2'b00, sel_3 = 2'b00;
  logic       hlock_1 = 1'b0, hlock_2 = 1'b0, hlock_3 = 1'b0;
  logic       hready_out = 1'b1;
  logic       hresp = 1'b0;
  logic       hgrant_1, hgrant_2, hgrant_3;
  logic [1:0] sel;
  logic [1:0] hmaster;
  logic       arb_err;

  int checks = 0;
  int failures = 0;

  // Reference model state: owner 0 means no master granted.
  int         m_owner = 0;
  int         m_last = 3;
  int         m_beats = 0;
  logic [2:0] e_grant = 3'b000;
  logic [1:0] e_hmaster = 2'b00;
  logic [1:0] e_sel = 2'b00;
  logic       e_err = 1'b0;

  ahb_rr_arbiter #(.MAX_BEATS(MAX_BEATS)) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hreq_1     (hreq_1),
    .hreq_2     (hreq_2),
    .hreq_3     (hreq_3),
    .sel_1      (sel_1),
    .sel_2      (sel_2),
    .sel_3      (sel_3),
`ifdef ARB_LOCK_EN
    .hlock_1    (hlock_1),
    .hlock_2    (hlock_2),
    .hlock_3    (hlock_3),
`endif
    .hready_out (hready_out),
    .hresp      (hresp),
    .hgrant_1   (hgrant_1),
    .hgrant_2   (hgrant_2),
    .hgrant_3   (hgrant_3),
    .sel        (sel),
    .hmaster    (hmaster),
    .arb_err    (arb_err)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int  rq [4];
    int  lk [4];
    int  sl [4];
    int  w;
    int  c;
    bit  done, err, other, expired, rel;
    rq[0] = 0; rq[1] = int'(hreq_1); rq[2] = int'(hreq_2); rq[3] = int'(hreq_3);
    sl[0] = 0; sl[1] = int'(sel_1);  sl[2] = int'(sel_2);  sl[3] = int'(sel_3);
    lk[0] = 0; lk[1] = 0; lk[2] = 0; lk[3] = 0;
`ifdef ARB_LOCK_EN
    lk[1] = int'(hlock_1); lk[2] = int'(hlock_2); lk[3] = int'(hlock_3);
`endif
    if (hreset) begin
      m_owner = 0; m_last = 3; m_beats = 0;
      e_hmaster = 2'b00; e_sel = 2'b00; e_err = 1'b0;
    end else if (m_owner == 0) begin
      e_err = 1'b0;
      w = 0;
      for (int i = 1; i <= 3; i++) begin
        c = (m_last + i - 1) % 3 + 1;
        if (w == 0 && rq[c] != 0) w = c;
      end
      if (w != 0) begin
        m_owner = w; m_last = w; m_beats = 0;
        e_hmaster = 2'(w); e_sel = 2'(sl[w]);
      end else begin
        e_hmaster = 2'b00; e_sel = 2'b00;
      end
    end else begin
      done    = hready_out && !hresp;
      err     = hready_out && hresp;
      other   = 1'b0;
      for (int i = 1; i <= 3; i++) if (i != m_owner && rq[i] != 0) other = 1'b1;
      expired = (m_beats >= MAX_BEATS - 1);
      rel     = err || (hready_out && rq[m_owner] == 0) ||
                (done && expired && other && lk[m_owner] == 0);
      e_err   = err;
      if (rel) begin
        e_hmaster = err ? 2'(m_owner) : 2'b00;
        e_sel     = 2'b00;
        m_owner   = 0;
      end else begin
        if (done) m_beats++;
        e_hmaster = 2'(m_owner);
        e_sel     = 2'(sl[m_owner]);
      end
    end
    e_grant = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
  endtask

  task automatic cycle();
    @(posedge hclk);
    model_step();
    #1;
    check("grant",   {5'b0, hgrant_3, hgrant_2, hgrant_1}, {5'b0, e_grant});
    check("hmaster", {6'b0, hmaster}, {6'b0, e_hmaster});
    check("sel",     {6'b0, sel},     {6'b0, e_sel});
    check("arb_err", {7'b0, arb_err}, {7'b0, e_err});
  endtask

  task automatic set_req(input logic r1, input logic r2, input logic r3);
    hreq_1 = r1; hreq_2 = r2; hreq_3 = r3;
  endtask

  int rr_exp [16] = '{1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 3, 3, 3, 3, 0, 1};
  int sat;

  initial begin
    // Reset with every master requesting
    hreset = 1'b1; set_req(1, 1, 1); sel_1 = 2'b01; sel_2 = 2'b10; sel_3 = 2'b11;
    hready_out = 1'b1; hresp = 1'b0;
    cycle(); cycle();
    check("rst_grant", {5'b0, hgrant_3, hgrant_2, hgrant_1}, 8'h00);
    check("rst_hmaster", {6'b0, hmaster}, 8'h00);
    hreset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("rr_seq", {6'b0, hmaster}, 8'(rr_exp[i]));
    end

    // Lone requester keeps the bus, counter saturates
    hreset = 1'b1; set_req(0, 1, 0); cycle(); hreset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      sat = (k < MAX_BEATS - 1) ? k : MAX_BEATS - 1;
      check("solo_grant2", {7'b0, hgrant_2}, 8'h01);
      check("solo_cnt", 8'(dut.beat_cnt), 8'(sat));
    end

    // Error response on master 1's second beat
    hreset = 1'b1; set_req(1, 1, 0); cycle(); hreset = 1'b0;
    cycle(); cycle();
    hresp = 1'b1; cycle(); hresp = 1'b0;
    check("err_pulse", {7'b0, arb_err}, 8'h01);
    check("err_hmaster", {6'b0, hmaster}, 8'h01);
    check("err_grant", {5'b0, hgrant_3, hgrant_2, hgrant_1}, 8'h00);
    cycle();
    check("err_next", {6'b0, hmaster}, 8'h02);
    check("err_clear", {7'b0, arb_err}, 8'h00);

    // Expired quantum held through wait states
    hreset = 1'b1; set_req(1, 0, 0); cycle(); hreset = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    hreq_3 = 1'b1; hready_out = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("wait_hold", {7'b0, hgrant_1}, 8'h01);
    end
    hready_out = 1'b1; cycle();
    check("wait_release", {5'b0, hgrant_3, hgrant_2, hgrant_1}, 8'h00);
    cycle();
    check("wait_next", {6'b0, hmaster}, 8'h03);

`ifdef ARB_LOCK_EN
    // Locked owner ignores the quantum until the lock falls
    hreset = 1'b1; set_req(1, 1, 1); hlock_1 = 1'b1; cycle(); hreset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("lock_hold", {6'b0, hmaster}, 8'h01);
    end
    hlock_1 = 1'b0; cycle();
    check("lock_release", {7'b0, hgrant_1}, 8'h00);
`endif

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      hreset     = ($urandom_range(0, 79) == 0);
      hreq_1     = ($urandom_range(0, 9) < 6);
      hreq_2     = ($urandom_range(0, 9) < 6);
      hreq_3     = ($urandom_range(0, 9) < 6);
      sel_1      = 2'($urandom_range(0, 3));
      sel_2      = 2'($urandom_range(0, 3));
      sel_3      = 2'($urandom_range(0, 3));
      hlock_1    = ($urandom_range(0, 3) == 0);
      hlock_2    = ($urandom_range(0, 3) == 0);
      hlock_3    = ($urandom_range(0, 3) == 0);
      hready_out = ($urandom_range(0, 3) != 0);
      hresp      = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
# ahb_rr_arbiter

Round-robin bus arbiter for three AHB masters sharing one address/write mux path to the slaves. It owns the grant lines and the slave-select mux control. A per-tenure beat quantum stops one master from monopolising the bus. Every handover inserts exactly one idle cycle with no master granted.

## Interface
- MAX_BEATS, default 4: completed beats a master may keep the bus while another master is requesting; legal range 1..255.
- CNT_W, default $clog2(MAX_BEATS+1): beat counter width.
- hclk  in  1  bus clock; one clock for the whole block.
- hreset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- hreq_1, hreq_2, hreq_3  in  1 each  bus request from master 1/2/3.
- sel_1, sel_2, sel_3  in  2 each  slave select driven by master 1/2/3.
- hready_out  in  1  ready from the selected slave.
- hresp  in  1  error response from the selected slave; qualified by hready_out.
- hgrant_1, hgrant_2, hgrant_3  out  1 each  one-hot grant, or all low.
- sel  out  2  mux select; follows the owner's sel_x, 2'b00 when no owner.
- hmaster  out  2  owner ID: 00 = none, 01/10/11 = master 1/2/3.
- arb_err  out  1  one-cycle pulse when the owner receives an error response.

## Operation
- States:
  - IDLE: no owner; arbitration happens here.
  - GRANT: one owner.
- Round-robin pointer `last` holds the ID of the most recent owner. Search order is last+1, last+2, last+3, wrapping 3→1. The first requester found wins.
- Derived terms:
  - done = hready_out & ~hresp
  - err = hready_out & hresp
  - other = any hreq_x asserted except the owner's
  - last_beat = (beat_cnt == MAX_BEATS-1)
- IDLE → GRANT when any hreq_x is high. On entry: owner = winner, last = winner, beat_cnt = 0.
- In GRANT, beat_cnt increments on each done. It saturates at MAX_BEATS-1; it never wraps.
- GRANT → IDLE (release) when any of these holds:
  - err
  - hready_out & ~hreq_owner
  - done & last_beat & other
- With no competing request, the owner keeps the bus indefinitely.
- While hready_out = 0, a release is never taken. Wait states always hold the grant, even if the quantum has expired.
- Release always passes through one IDLE cycle. A new grant is never issued on the release cycle.
- arb_err = 1 for the cycle err is sampled in GRANT. On that cycle hmaster still shows the faulting master.
- Reset values:
  - state = IDLE
  - last = 3, so master 1 has first priority after reset
  - hgrant_1..3 = 0
  - sel = 00
  - hmaster = 00
  - arb_err = 0
  - beat_cnt = 0
- Reset mid-tenure: all grants are low after the reset edge. The in-flight transfer is abandoned.

## Timing
- All outputs are registered and decoded from next state/owner. They are valid in the same cycle the state reads GRANT or IDLE.
- Grant latency: a request sampled at edge k in IDLE gives hgrant_x = 1 after edge k.
- Release: condition sampled at edge k drops grants after edge k. The next grant appears no earlier than after edge k+1, giving a one-cycle gap.
- sel is re-registered every GRANT cycle from the owner's sel_x, so a master's sel change appears one cycle later.
- arb_err is registered, asserted after the edge that samples err, and held for exactly one cycle.

## Configuration
- ARB_LOCK_EN defined:
  - Adds inputs hlock_1, hlock_2, hlock_3 (1 bit each).
  - While the owner's hlock_x = 1, the quantum release (done & last_beat & other) is suppressed.
  - err and request-drop releases still apply.
  - Quantum release resumes on the first done after hlock_x falls, provided the counter is at last_beat.
- ARB_LOCK_EN undefined: the hlock ports are absent and behaviour is identical to hlock_x = 0.

## Structure
- Package ahb_arb_pkg contains:
  - state enum {IDLE, GRANT}
  - master ID constants M_NONE = 2'b00, M1 = 2'b01, M2 = 2'b10, M3 = 2'b11
  - SEL_DEFAULT = 2'b00
- Sub-module ahb_rr_pick: purely combinational. Takes the 3 request bits and `last`, and returns the winner ID plus an any_req flag. The top level holds the state, pointer, counter and output registers.

## Test plan
- Reset: hreset = 1 for 2 cycles with all hreq high → all grants 0, sel 00, hmaster 00, arb_err 0; one cycle after hreset falls, hgrant_1 = 1.
- All three hreq held, MAX_BEATS = 4, hready_out = 1, hresp = 0 → master 1 for 4 cycles, 1 idle cycle, master 2 for 4, idle, master 3 for 4, idle, then master 1 again.
- Only hreq_2 held for 20 cycles with hready_out = 1 → hgrant_2 stays high throughout, hmaster = 10, and beat_cnt saturates at 3 without wrapping.
- Master 1 owns the bus; on its 2nd beat hresp = 1 with hready_out = 1 → arb_err pulse with hmaster = 01, grant drops next cycle, master 2 is granted after the one-cycle gap.
- Quantum expired with hreq_3 pending, then hready_out = 0 for 5 cycles → hgrant_1 held through all 5 cycles and released on the first done.
- With ARB_LOCK_EN, hlock_1 = 1 and all requests held → master 1 holds past 4 beats; after hlock_1 falls, master 1 releases on the next done.
